// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes, FSM states
// and the bit-counter width helper.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_DONE,
      ST_WAIT_HI
   } rx_state_t;

   function automatic int cnt_width(input int clks);
      return (clks <= 2) ? 1 : $clog2(clks);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the serial line plus a majority-of-3 voter: two samples are
// held in flops, the third is the live synced level on the decision cycle.
module uart_rx_sampler (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Rx_Serial,
   input  logic i_Sample_A,
   input  logic i_Sample_B,
   output logic o_Line,
   output logic o_Bit
);

   logic meta;
   logic sync;
   logic smp_a;
   logic smp_b;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         meta  <= 1'b1;
         sync  <= 1'b1;
         smp_a <= 1'b0;
         smp_b <= 1'b0;
      end else begin
         meta <= i_Rx_Serial;
         sync <= meta;
         if (i_Sample_A) smp_a <= sync;
         if (i_Sample_B) smp_b <= sync;
      end
   end

   assign o_Line = sync;
   assign o_Bit  = (smp_a & smp_b) | (smp_a & sync) | (smp_b & sync);

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver (5-9 data bits, none/odd/even parity, 1-2 stop bits) with
// majority mid-bit sampling, glitch-rejecting start detect and parity/framing/break flags.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_Rx_Serial,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Break,
   output logic                 o_Busy,
   output rx_state_t            o_State
);

   localparam int CW  = cnt_width(CLKS_PER_BIT);
   localparam int IW  = $clog2(DATA_BITS);
   localparam int MID = (CLKS_PER_BIT - 1) / 2;
   localparam logic [CW-1:0] CNT_MID_M1 = CW'(MID - 1);
   localparam logic [CW-1:0] CNT_MID    = CW'(MID);
   localparam logic [CW-1:0] CNT_MID_P1 = CW'(MID + 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_BITS - 1);
   localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);
   localparam bit            PAR_ON     = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);

   rx_state_t            state;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr;
   logic                 ferr;
   logic                 all_low;
   logic                 rx_line;
   logic                 vote;
   logic                 at_mid1;
   logic                 at_wrap;
   logic                 exp_par;

   uart_rx_sampler u_sampler (
      .i_Clock     (i_Clock),
      .i_Reset     (i_Reset),
      .i_Rx_Serial (i_Rx_Serial),
      .i_Sample_A  (cnt == CNT_MID_M1),
      .i_Sample_B  (cnt == CNT_MID),
      .o_Line      (rx_line),
      .o_Bit       (vote)
   );

   assign at_mid1 = (cnt == CNT_MID_P1);
   assign at_wrap = (cnt == CNT_LAST);
   assign exp_par = (PARITY == PAR_EVEN) ? ^shreg : ~^shreg;
   assign o_State = state;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         idx          <= '0;
         stop_idx     <= 1'b0;
         shreg        <= '0;
         perr         <= 1'b0;
         ferr         <= 1'b0;
         all_low      <= 1'b0;
         o_Rx_DV      <= 1'b0;
         o_Rx_Byte    <= '0;
         o_Parity_Err <= 1'b0;
         o_Frame_Err  <= 1'b0;
         o_Break      <= 1'b0;
         o_Busy       <= 1'b0;
      end else begin
         o_Rx_DV <= 1'b0;
         cnt     <= at_wrap ? '0 : cnt + 1'b1;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (!rx_line) begin
                  state    <= ST_START;
                  cnt      <= CW'(1);
                  o_Busy   <= 1'b1;
                  idx      <= '0;
                  stop_idx <= 1'b0;
                  perr     <= 1'b0;
                  ferr     <= 1'b0;
                  all_low  <= 1'b1;
               end
            end
            ST_START: begin
               if (at_mid1 && vote) begin
                  state  <= ST_IDLE;
                  cnt    <= '0;
                  o_Busy <= 1'b0;
               end else if (at_wrap) begin
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               // LSB arrives first, so after DATA_BITS shifts it sits at bit 0
               if (at_mid1) begin
                  shreg <= {vote, shreg[DATA_BITS-1:1]};
                  if (vote) all_low <= 1'b0;
               end
               if (at_wrap) begin
                  if (idx == IDX_LAST) state <= PAR_ON ? ST_PARITY : ST_STOP;
                  else idx <= idx + 1'b1;
               end
            end
            ST_PARITY: begin
               if (at_mid1) begin
                  if (vote != exp_par) perr <= 1'b1;
                  if (vote) all_low <= 1'b0;
               end
               if (at_wrap) state <= ST_STOP;
            end
            ST_STOP: begin
               if (at_mid1) begin
                  if (!vote) ferr <= 1'b1;
                  if (vote) all_low <= 1'b0;
                  // Finish at mid-bit of the last stop bit so a slightly fast sender's
                  // next start edge is still caught.
                  if (stop_idx == STOP_LAST) begin
                     state        <= ST_DONE;
                     cnt          <= '0;
                     o_Rx_DV      <= 1'b1;
                     o_Rx_Byte    <= shreg;
                     o_Parity_Err <= perr;
                     o_Frame_Err  <= ferr | ~vote;
                     o_Break      <= all_low & ~vote;
                  end
               end
               if (at_wrap) stop_idx <= 1'b1;
            end
            ST_DONE: begin
               cnt <= '0;
               if (o_Frame_Err) begin
                  state <= ST_WAIT_HI;
               end else if (!rx_line) begin
                  state    <= ST_START;
                  cnt      <= CW'(1);
                  idx      <= '0;
                  stop_idx <= 1'b0;
                  perr     <= 1'b0;
                  ferr     <= 1'b0;
                  all_low  <= 1'b1;
               end else begin
                  state  <= ST_IDLE;
                  o_Busy <= 1'b0;
               end
            end
            ST_WAIT_HI: begin
               cnt <= '0;
               if (rx_line) begin
                  state  <= ST_IDLE;
                  o_Busy <= 1'b0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               o_Busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
